// File: rtl/glb_access_scheduler_if.sv
// Bundle of the lane-side request/grant/return signals and the GLB port seen by the scheduler.
// The scheduler takes the master view. Lane FIFOs and the GLB model take the slave view.
interface glb_access_scheduler_if #(
    parameter int NUM_LANE = 32,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [NUM_LANE-1:0]              ifmap_req_i;
    logic [NUM_LANE-1:0][ADDR_W-1:0]  ifmap_addr_i;
    logic [NUM_LANE-1:0]              ipsum_req_i;
    logic [NUM_LANE-1:0][ADDR_W-1:0]  ipsum_addr_i;
    logic [NUM_LANE-1:0]              opsum_req_i;
    logic [NUM_LANE-1:0][ADDR_W-1:0]  opsum_addr_i;
    logic [NUM_LANE-1:0][DATA_W-1:0]  opsum_wdata_i;
    logic [NUM_LANE-1:0][3:0]         opsum_web_i;

    logic [NUM_LANE-1:0]              ifmap_grant_o;
    logic [NUM_LANE-1:0]              ipsum_grant_o;
    logic [NUM_LANE-1:0]              opsum_grant_o;

    logic                             glb_en_o;
    logic [3:0]                       glb_web_o;
    logic [ADDR_W-1:0]                glb_addr_o;
    logic [DATA_W-1:0]                glb_wdata_o;
    logic [DATA_W-1:0]                glb_rdata_i;

    logic [NUM_LANE-1:0]              ifmap_rvalid_o;
    logic [NUM_LANE-1:0]              ipsum_rvalid_o;
    logic [DATA_W-1:0]                rdata_o;

    modport master (
        input  ifmap_req_i, ifmap_addr_i, ipsum_req_i, ipsum_addr_i,
        input  opsum_req_i, opsum_addr_i, opsum_wdata_i, opsum_web_i,
        input  glb_rdata_i,
        output ifmap_grant_o, ipsum_grant_o, opsum_grant_o,
        output glb_en_o, glb_web_o, glb_addr_o, glb_wdata_o,
        output ifmap_rvalid_o, ipsum_rvalid_o, rdata_o
    );

    modport slave (
        output ifmap_req_i, ifmap_addr_i, ipsum_req_i, ipsum_addr_i,
        output opsum_req_i, opsum_addr_i, opsum_wdata_i, opsum_web_i,
        output glb_rdata_i,
        input  ifmap_grant_o, ipsum_grant_o, opsum_grant_o,
        input  glb_en_o, glb_web_o, glb_addr_o, glb_wdata_o,
        input  ifmap_rvalid_o, ipsum_rvalid_o, rdata_o
    );
endinterface

// File: rtl/glb_access_scheduler.sv
// Shares the single GLB port among opsum-write, ipsum-read and ifmap-read lanes using
// round-robin over classes, then round-robin over lanes within the winning class.
module glb_access_scheduler #(
    parameter int NUM_LANE = 32,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    glb_access_scheduler_if.master        bus
);
    localparam int LW = $clog2(NUM_LANE);

    localparam logic [1:0] CLS_OPSUM = 2'd0;
    localparam logic [1:0] CLS_IPSUM = 2'd1;
    localparam logic [1:0] CLS_IFMAP = 2'd2;

    logic [2:0][NUM_LANE-1:0] req;
    logic [2:0][NUM_LANE-1:0] elig;
    logic [2:0][NUM_LANE-1:0] gnt_q, gnt_d;
    logic [2:0][LW-1:0]       lane_ptr_q, lane_ptr_d;
    logic [2:0][LW-1:0]       lane_win;
    logic [2:0]               cls_any;
    logic [1:0]               cls_ptr_q, cls_ptr_d;
    logic [1:0]               win_cls;
    logic                     win_found;

    logic                     en_q, en_d;
    logic [3:0]               web_q, web_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [NUM_LANE-1:0]      if_rv_q, if_rv_d;
    logic [NUM_LANE-1:0]      ip_rv_q, ip_rv_d;

    function automatic logic [1:0] cls_next(input logic [1:0] c);
        return (c == CLS_IFMAP) ? CLS_OPSUM : c + 2'd1;
    endfunction

    assign req[CLS_OPSUM] = bus.opsum_req_i;
    assign req[CLS_IPSUM] = bus.ipsum_req_i;
    assign req[CLS_IFMAP] = bus.ifmap_req_i;

    // A lane still showing its grant this cycle is masked so a lagging req cannot win twice.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cls
        logic [LW-1:0] win;
        logic [LW-1:0] idx;
        logic          found;

        assign elig[gi]     = req[gi] & ~gnt_q[gi];
        assign cls_any[gi]  = |elig[gi];
        assign lane_win[gi] = win;

        always_comb begin
            win   = '0;
            idx   = '0;
            found = 1'b0;
            for (int k = 0; k < NUM_LANE; k++) begin
                idx = lane_ptr_q[gi] + LW'(k);
                if (!found && elig[gi][idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [1:0] c;
        win_cls   = CLS_OPSUM;
        win_found = 1'b0;
        c         = cls_ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!win_found && cls_any[c]) begin
                win_cls   = c;
                win_found = 1'b1;
            end
            c = cls_next(c);
        end
    end

    always_comb begin
        gnt_d      = '0;
        en_d       = 1'b0;
        web_d      = 4'b1111;
        addr_d     = '0;
        wdata_d    = '0;
        lane_ptr_d = lane_ptr_q;
        cls_ptr_d  = cls_ptr_q;
        // The grant currently on the bus doubles as the read tag for the next cycle.
        if_rv_d    = gnt_q[CLS_IFMAP];
        ip_rv_d    = gnt_q[CLS_IPSUM];

        if (flush_i) begin
            if_rv_d    = '0;
            ip_rv_d    = '0;
            lane_ptr_d = '0;
            cls_ptr_d  = CLS_OPSUM;
        end else if (win_found) begin
            en_d                         = 1'b1;
            gnt_d[win_cls][lane_win[win_cls]] = 1'b1;
            lane_ptr_d[win_cls]          = lane_win[win_cls] + LW'(1);
            cls_ptr_d                    = cls_next(win_cls);
            case (win_cls)
                CLS_OPSUM: begin
                    addr_d  = bus.opsum_addr_i[lane_win[CLS_OPSUM]];
                    wdata_d = bus.opsum_wdata_i[lane_win[CLS_OPSUM]];
                    web_d   = bus.opsum_web_i[lane_win[CLS_OPSUM]];
                end
                CLS_IPSUM: addr_d = bus.ipsum_addr_i[lane_win[CLS_IPSUM]];
                default:   addr_d = bus.ifmap_addr_i[lane_win[CLS_IFMAP]];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= '0;
            en_q       <= 1'b0;
            web_q      <= 4'b1111;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rv_q    <= '0;
            ip_rv_q    <= '0;
            lane_ptr_q <= '0;
            cls_ptr_q  <= CLS_OPSUM;
        end else begin
            gnt_q      <= gnt_d;
            en_q       <= en_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rv_q    <= if_rv_d;
            ip_rv_q    <= ip_rv_d;
            lane_ptr_q <= lane_ptr_d;
            cls_ptr_q  <= cls_ptr_d;
        end
    end

    assign bus.opsum_grant_o  = gnt_q[CLS_OPSUM];
    assign bus.ipsum_grant_o  = gnt_q[CLS_IPSUM];
    assign bus.ifmap_grant_o  = gnt_q[CLS_IFMAP];
    assign bus.glb_en_o       = en_q;
    assign bus.glb_web_o      = web_q;
    assign bus.glb_addr_o     = addr_q;
    assign bus.glb_wdata_o    = wdata_q;
    assign bus.ifmap_rvalid_o = if_rv_q;
    assign bus.ipsum_rvalid_o = ip_rv_q;
    assign bus.rdata_o        = bus.glb_rdata_i;
endmodule

// File: tb/tb_glb_access_scheduler.sv
// Scenario tasks for the GLB access scheduler plus a randomized run against a
// behavioural arbitration model kept in this file.
module tb_glb_access_scheduler;
    localparam int NL = 32;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    glb_access_scheduler_if #(.NUM_LANE(NL), .ADDR_W(AW), .DATA_W(DW)) bus ();

    glb_access_scheduler #(.NUM_LANE(NL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus)
    );

    // Model state: class index 0=opsum, 1=ipsum, 2=ifmap.
    int              m_cls;
    int              m_ptr [3];
    logic [NL-1:0]   m_gnt [3];
    logic            m_en;
    logic [3:0]      m_web;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [NL-1:0]   m_rv_if, m_rv_ip;

    task automatic model_reset();
        m_cls = 0;
        for (int c = 0; c < 3; c++) begin
            m_ptr[c] = 0;
            m_gnt[c] = '0;
        end
        m_en = 1'b0; m_web = 4'hF; m_addr = '0; m_wdata = '0;
        m_rv_if = '0; m_rv_ip = '0;
    endtask

    // Predicts the registered outputs after the coming rising edge.
    task automatic model_step();
        logic [NL-1:0] rq [3];
        logic [NL-1:0] el [3];
        int wc, wl;
        if (!rst_n || flush_i) begin
            model_reset();
            return;
        end
        rq[0] = bus.opsum_req_i; rq[1] = bus.ipsum_req_i; rq[2] = bus.ifmap_req_i;
        for (int c = 0; c < 3; c++) el[c] = rq[c] & ~m_gnt[c];
        m_rv_if = m_gnt[2];
        m_rv_ip = m_gnt[1];
        wc = -1;
        for (int k = 0; k < 3; k++)
            if (wc < 0 && el[(m_cls + k) % 3] != '0) wc = (m_cls + k) % 3;
        for (int c = 0; c < 3; c++) m_gnt[c] = '0;
        if (wc < 0) begin
            m_en = 1'b0; m_web = 4'hF; m_addr = '0; m_wdata = '0;
        end else begin
            wl = -1;
            for (int k = 0; k < NL; k++)
                if (wl < 0 && el[wc][(m_ptr[wc] + k) % NL]) wl = (m_ptr[wc] + k) % NL;
            m_gnt[wc][wl] = 1'b1;
            m_en = 1'b1;
            m_ptr[wc] = (wl + 1) % NL;
            m_cls = (wc + 1) % 3;
            if (wc == 0) begin
                m_addr = bus.opsum_addr_i[wl]; m_wdata = bus.opsum_wdata_i[wl]; m_web = bus.opsum_web_i[wl];
            end else begin
                m_addr = (wc == 1) ? bus.ipsum_addr_i[wl] : bus.ifmap_addr_i[wl];
                m_wdata = '0; m_web = 4'hF;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.ifmap_req_i = '0;
        bus.ipsum_req_i = '0;
        bus.opsum_req_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic do_flush();
        clear_reqs();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (bus.ifmap_grant_o !== '0 || bus.ipsum_grant_o !== '0 || bus.opsum_grant_o !== '0 ||
            bus.glb_en_o !== 1'b0 || bus.glb_web_o !== 4'hF || bus.glb_addr_o !== '0 ||
            bus.glb_wdata_o !== '0 || bus.ifmap_rvalid_o !== '0 || bus.ipsum_rvalid_o !== '0) begin
            bad++;
            $display("FAIL reset_state en=%b web=%h addr=%h gnt_if=%h want en=0 web=f addr=0 gnt=0",
                     bus.glb_en_o, bus.glb_web_o, bus.glb_addr_o, bus.ifmap_grant_o);
        end
        $display("reset: en=%b web=%h", bus.glb_en_o, bus.glb_web_o);
    endtask

    task automatic test_single_read();
        do_flush();
        bus.ifmap_addr_i[5] = 32'h100;
        bus.ifmap_req_i[5]  = 1'b1;
        tick();
        bus.ifmap_req_i = '0;
        bus.glb_rdata_i = 32'hCAFE_0005;
        total++;
        if (bus.ifmap_grant_o !== 32'h20 || bus.glb_en_o !== 1'b1 ||
            bus.glb_addr_o !== 32'h100 || bus.glb_web_o !== 4'hF || bus.glb_wdata_o !== '0) begin
            bad++;
            $display("FAIL single_read_cmd gnt=%h en=%b addr=%h web=%h want gnt=20 en=1 addr=100 web=f",
                     bus.ifmap_grant_o, bus.glb_en_o, bus.glb_addr_o, bus.glb_web_o);
        end
        tick();
        total++;
        if (bus.ifmap_rvalid_o !== 32'h20 || bus.ipsum_rvalid_o !== '0 || bus.rdata_o !== 32'hCAFE_0005) begin
            bad++;
            $display("FAIL single_read_ret rvalid=%h rdata=%h want rvalid=20 rdata=cafe0005",
                     bus.ifmap_rvalid_o, bus.rdata_o);
        end
        $display("single_read: lane5 rvalid=%h rdata=%h", bus.ifmap_rvalid_o, bus.rdata_o);
    endtask

    task automatic test_all_ifmap();
        logic [NL-1:0] exp_g;
        do_flush();
        bus.ifmap_req_i = '1;
        for (int i = 0; i < NL; i++) begin
            tick();
            exp_g = '0;
            exp_g[i] = 1'b1;
            total++;
            if (bus.ifmap_grant_o !== exp_g || bus.glb_en_o !== 1'b1 ||
                bus.ipsum_grant_o !== '0 || bus.opsum_grant_o !== '0) begin
                bad++;
                $display("FAIL all_ifmap_step%0d gnt=%h en=%b want gnt=%h en=1",
                         i, bus.ifmap_grant_o, bus.glb_en_o, exp_g);
            end
            if (i > 0) bus.ifmap_req_i[i-1] = 1'b0;
        end
        bus.ifmap_req_i = '0;
        $display("all_ifmap: 32 consecutive grants checked");
    endtask

    task automatic test_class_rr();
        logic [NL-1:0] e_op, e_ip, e_if;
        do_flush();
        bus.opsum_addr_i[3] = 32'h300; bus.opsum_wdata_i[3] = 32'h1234; bus.opsum_web_i[3] = 4'h0;
        bus.ipsum_addr_i[7] = 32'h700;
        bus.ifmap_addr_i[9] = 32'h900;
        bus.opsum_req_i[3] = 1'b1; bus.ipsum_req_i[7] = 1'b1; bus.ifmap_req_i[9] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            e_op = (i % 3 == 0) ? 32'h8 : '0;
            e_ip = (i % 3 == 1) ? 32'h80 : '0;
            e_if = (i % 3 == 2) ? 32'h200 : '0;
            total++;
            if (bus.opsum_grant_o !== e_op || bus.ipsum_grant_o !== e_ip || bus.ifmap_grant_o !== e_if) begin
                bad++;
                $display("FAIL class_rr_step%0d op=%h ip=%h if=%h want op=%h ip=%h if=%h",
                         i, bus.opsum_grant_o, bus.ipsum_grant_o, bus.ifmap_grant_o, e_op, e_ip, e_if);
            end
        end
        clear_reqs();
        $display("class_rr: opsum3/ipsum7/ifmap9 rotation checked");
    endtask

    task automatic test_write();
        do_flush();
        bus.opsum_addr_i[2] = 32'h40; bus.opsum_wdata_i[2] = 32'hDEAD_BEEF; bus.opsum_web_i[2] = 4'b1100;
        bus.opsum_req_i[2] = 1'b1;
        tick();
        bus.opsum_req_i = '0;
        total++;
        if (bus.opsum_grant_o !== 32'h4 || bus.glb_en_o !== 1'b1 || bus.glb_addr_o !== 32'h40 ||
            bus.glb_web_o !== 4'b1100 || bus.glb_wdata_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_cmd gnt=%h addr=%h web=%h wdata=%h want gnt=4 addr=40 web=c wdata=deadbeef",
                     bus.opsum_grant_o, bus.glb_addr_o, bus.glb_web_o, bus.glb_wdata_o);
        end
        tick();
        total++;
        if (bus.ifmap_rvalid_o !== '0 || bus.ipsum_rvalid_o !== '0) begin
            bad++;
            $display("FAIL write_no_rvalid if=%h ip=%h want 0", bus.ifmap_rvalid_o, bus.ipsum_rvalid_o);
        end
        $display("write: web=%h wdata=%h", 4'b1100, 32'hDEAD_BEEF);
    endtask

    task automatic test_flush();
        do_flush();
        bus.ipsum_addr_i[4] = 32'h444;
        bus.ipsum_req_i[4] = 1'b1;
        tick();
        total++;
        if (bus.ipsum_grant_o !== 32'h10 || bus.glb_en_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre_grant gnt=%h en=%b want gnt=10 en=1", bus.ipsum_grant_o, bus.glb_en_o);
        end
        bus.ipsum_req_i = '0;
        bus.ifmap_req_i[1] = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bus.ifmap_req_i = '0;
        total++;
        if (bus.ipsum_rvalid_o !== '0 || bus.glb_en_o !== 1'b0 || bus.ifmap_grant_o !== '0 ||
            bus.ipsum_grant_o !== '0) begin
            bad++;
            $display("FAIL flush_suppress rvalid=%h en=%b gnt_if=%h want all 0",
                     bus.ipsum_rvalid_o, bus.glb_en_o, bus.ifmap_grant_o);
        end
        bus.ifmap_addr_i[0] = 32'h0;
        bus.ifmap_req_i[0] = 1'b1;
        tick();
        bus.ifmap_req_i = '0;
        total++;
        if (bus.ifmap_grant_o !== 32'h1 || bus.glb_en_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_after_ifmap0 gnt=%h en=%b want gnt=1 en=1", bus.ifmap_grant_o, bus.glb_en_o);
        end
        tick();
        // ipsum pointer must be back at 0, so lane 2 beats lane 6
        bus.ipsum_req_i[2] = 1'b1; bus.ipsum_req_i[6] = 1'b1;
        tick();
        bus.ipsum_req_i = '0;
        total++;
        if (bus.ipsum_grant_o !== 32'h4) begin
            bad++;
            $display("FAIL flush_ptr_reset gnt=%h want 4", bus.ipsum_grant_o);
        end
        tick();
        $display("flush: rvalid suppressed, pointers reset");
    endtask

    task automatic test_async_reset();
        bus.ifmap_req_i = '1; bus.ipsum_req_i = '1; bus.opsum_req_i = '1;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (bus.ifmap_grant_o !== '0 || bus.ipsum_grant_o !== '0 || bus.opsum_grant_o !== '0 ||
            bus.glb_en_o !== 1'b0 || bus.glb_web_o !== 4'hF || bus.glb_addr_o !== '0 ||
            bus.glb_wdata_o !== '0 || bus.ifmap_rvalid_o !== '0 || bus.ipsum_rvalid_o !== '0) begin
            bad++;
            $display("FAIL async_reset en=%b web=%h addr=%h op=%h want en=0 web=f addr=0 op=0",
                     bus.glb_en_o, bus.glb_web_o, bus.glb_addr_o, bus.opsum_grant_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.opsum_grant_o !== 32'h1 || bus.ipsum_grant_o !== '0 || bus.ifmap_grant_o !== '0 ||
            bus.glb_en_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_restart op=%h ip=%h if=%h want op=1", bus.opsum_grant_o,
                     bus.ipsum_grant_o, bus.ifmap_grant_o);
        end
        tick();
        total++;
        if (bus.ipsum_grant_o !== 32'h1 || bus.opsum_grant_o !== '0) begin
            bad++;
            $display("FAIL reset_restart2 ip=%h op=%h want ip=1 op=0", bus.ipsum_grant_o, bus.opsum_grant_o);
        end
        clear_reqs();
        tick();
        $display("async_reset: restart at opsum lane0 checked");
    endtask

    task automatic test_random();
        int n_err0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int l = 0; l < NL; l++) begin
                if (!bus.ifmap_req_i[l]) bus.ifmap_addr_i[l] = $urandom;
                if (!bus.ipsum_req_i[l]) bus.ipsum_addr_i[l] = $urandom;
                if (!bus.opsum_req_i[l]) begin
                    bus.opsum_addr_i[l]  = $urandom;
                    bus.opsum_wdata_i[l] = $urandom;
                    bus.opsum_web_i[l]   = 4'($urandom);
                end
            end
            if ($urandom_range(0, 3) == 0) bus.ifmap_req_i |= $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) bus.ipsum_req_i |= $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) bus.opsum_req_i |= $urandom & $urandom & $urandom;
            flush_i = ($urandom_range(0, 24) == 0);
            bus.glb_rdata_i = $urandom;
            n_err0 = bad;
            tick();
            total++;
            if (bus.opsum_grant_o !== m_gnt[0] || bus.ipsum_grant_o !== m_gnt[1] ||
                bus.ifmap_grant_o !== m_gnt[2] || bus.glb_en_o !== m_en) begin
                bad++;
                $display("FAIL rand_grant cyc%0d op=%h ip=%h if=%h en=%b want op=%h ip=%h if=%h en=%b", cyc,
                         bus.opsum_grant_o, bus.ipsum_grant_o, bus.ifmap_grant_o, bus.glb_en_o,
                         m_gnt[0], m_gnt[1], m_gnt[2], m_en);
            end
            total++;
            if (bus.glb_web_o !== m_web || (m_en && (bus.glb_addr_o !== m_addr || bus.glb_wdata_o !== m_wdata))) begin
                bad++;
                $display("FAIL rand_cmd cyc%0d web=%h addr=%h wdata=%h want web=%h addr=%h wdata=%h", cyc,
                         bus.glb_web_o, bus.glb_addr_o, bus.glb_wdata_o, m_web, m_addr, m_wdata);
            end
            total++;
            if (bus.ifmap_rvalid_o !== m_rv_if || bus.ipsum_rvalid_o !== m_rv_ip ||
                bus.rdata_o !== bus.glb_rdata_i) begin
                bad++;
                $display("FAIL rand_rvalid cyc%0d if=%h ip=%h want if=%h ip=%h", cyc,
                         bus.ifmap_rvalid_o, bus.ipsum_rvalid_o, m_rv_if, m_rv_ip);
            end
            if (bad == n_err0 && (cyc % 50) == 0)
                $display("random cyc%0d en=%b addr=%h", cyc, m_en, m_addr);
            bus.opsum_req_i &= ~m_gnt[0];
            bus.ipsum_req_i &= ~m_gnt[1];
            bus.ifmap_req_i &= ~m_gnt[2];
        end
        clear_reqs();
    endtask

    initial begin
        bus.ifmap_addr_i = '0; bus.ipsum_addr_i = '0; bus.opsum_addr_i = '0;
        bus.opsum_wdata_i = '0; bus.opsum_web_i = '1; bus.glb_rdata_i = '0;
        clear_reqs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_single_read();
        test_all_ifmap();
        test_class_rr();
        test_write();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
